mem_copy_dma: RTL and testbench

MEM_COPY_DMA -- requirements
Module: mem_copy_dma

---
 rtl/mem_copy_dma_if.sv | 37 +++
 rtl/mem_copy_dma.sv | 159 +++++++++++++++
 tb/tb_mem_copy_dma.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_dma_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_copy_dma_if                                                  |
// | Purpose  : Bundles the copy-request handshake and the data-memory bus of    |
// |            mem_copy_dma into one interface.                                 |
// | Signals  : start/src_addr/dst_addr/len_words  request from the host         |
// |            busy/done/error                    status back to the host       |
// |            Addr/write_data/mem_read/mem_write access to data memory         |
// |            data_in                            combinational read data       |
// | Modports : master - the DMA engine; slave - host plus memory side           |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface mem_copy_dma_if;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len_words;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] Addr;
  logic [31:0] write_data;
  logic [31:0] data_in;
  logic        mem_read;
  logic        mem_write;

  modport master (
    input  start, src_addr, dst_addr, len_words, data_in,
    output busy, done, error, Addr, write_data, mem_read, mem_write
  );

  modport slave (
    output start, src_addr, dst_addr, len_words, data_in,
    input  busy, done, error, Addr, write_data, mem_read, mem_write
  );
endinterface
`default_nettype wire

// File: rtl/mem_copy_dma.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_copy_dma                                                     |
// | Purpose  : Word-by-word memory-to-memory copy engine. A request is checked  |
// |            for alignment and range, then each word is read in one cycle     |
// |            and written in the next, in ascending address order.             |
// | Ports    : clk  - clock, rising edge                                        |
// |            rst  - asynchronous active-high reset                            |
// |            bus  - mem_copy_dma_if.master (request, status, memory bus)      |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mem_copy_dma #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic           clk,
  input  logic           rst,
  mem_copy_dma_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic [33:0] c_mem_bytes = 34'(MEM_BYTES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_src;
  logic [31:0] w_src_nxt;
  logic [31:0] r_dst;
  logic [31:0] w_dst_nxt;
  logic [15:0] r_remaining;
  logic [15:0] w_remaining_nxt;
  logic [31:0] r_buffer;
  logic [31:0] w_buffer_nxt;

  logic        w_busy;
  logic        w_done;
  logic        w_error;
  logic        w_mem_read;
  logic        w_mem_write;
  logic [31:0] w_addr;
  logic [31:0] w_write_data;

  // End addresses are formed 34 bits wide so a request near the top of the
  // 32-bit space cannot wrap around and slip past the range check.
  logic [33:0] w_src_end;
  logic [33:0] w_dst_end;
  logic        w_reject;
  logic [15:0] w_remaining_dec;

  assign w_src_end = {2'b00, bus.src_addr} + {16'd0, bus.len_words, 2'b00};
  assign w_dst_end = {2'b00, bus.dst_addr} + {16'd0, bus.len_words, 2'b00};
  assign w_reject  = (bus.src_addr[1:0] != 2'b00) ||
                     (bus.dst_addr[1:0] != 2'b00) ||
                     (w_src_end > c_mem_bytes)    ||
                     (w_dst_end > c_mem_bytes);

  assign w_remaining_dec = r_remaining - 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_src       <= 32'd0;
      r_dst       <= 32'd0;
      r_remaining <= 16'd0;
      r_buffer    <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_src       <= w_src_nxt;
      r_dst       <= w_dst_nxt;
      r_remaining <= w_remaining_nxt;
      r_buffer    <= w_buffer_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_src_nxt       = r_src;
    w_dst_nxt       = r_dst;
    w_remaining_nxt = r_remaining;
    w_buffer_nxt    = r_buffer;
    w_busy          = 1'b1;
    w_done          = 1'b0;
    w_error         = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_addr          = 32'd0;
    w_write_data    = 32'd0;

    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        // Operands are only captured here, so a start pulse during a copy
        // cannot disturb the transfer already in flight.
        if (bus.start) begin
          w_src_nxt       = bus.src_addr;
          w_dst_nxt       = bus.dst_addr;
          w_remaining_nxt = bus.len_words;
          if (w_reject) begin
            w_state_nxt = ERR;
          end else if (bus.len_words == 16'd0) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = READ;
          end
        end
      end

      READ: begin
        w_mem_read   = 1'b1;
        w_addr       = r_src;
        w_buffer_nxt = bus.data_in;
        w_state_nxt  = WRITE;
      end

      WRITE: begin
        w_mem_write     = 1'b1;
        w_addr          = r_dst;
        w_write_data    = r_buffer;
        w_src_nxt       = r_src + 32'd4;
        w_dst_nxt       = r_dst + 32'd4;
        w_remaining_nxt = w_remaining_dec;
        w_state_nxt     = (w_remaining_dec != 16'd0) ? READ : DONE;
      end

      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end

      ERR: begin
        w_error     = 1'b1;
        w_state_nxt = IDLE;
      end

      default: begin
        w_busy      = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are masked by rst so that the memory sees no write strobe from
  // the moment reset rises, independent of when the state register clears.
  assign bus.busy       = w_busy       & ~rst;
  assign bus.done       = w_done       & ~rst;
  assign bus.error      = w_error      & ~rst;
  assign bus.mem_read   = w_mem_read   & ~rst;
  assign bus.mem_write  = w_mem_write  & ~rst;
  assign bus.Addr       = rst ? 32'd0 : w_addr;
  assign bus.write_data = rst ? 32'd0 : w_write_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_dma.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_copy_dma                                                  |
// | Purpose  : Self-checking bench for mem_copy_dma with a byte-wide            |
// |            big-endian memory model and a reference copy of memory contents. |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mem_copy_dma;

  logic clk;
  logic rst;
  mem_copy_dma_if bus ();

  mem_copy_dma #(.MEM_BYTES(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem     [0:1023];
  logic [7:0]  exp_mem [0:1023];
  logic        pl_we;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;
  logic [9:0]  rd_a;

  assign rd_a = bus.Addr[9:0];
  assign bus.data_in = bus.mem_read ?
      {mem[rd_a], mem[rd_a + 10'd1], mem[rd_a + 10'd2], mem[rd_a + 10'd3]} : 32'd0;

  always @(posedge clk) begin
    if (pl_we) begin
      mem[pl_addr]         <= pl_data[31:24];
      mem[pl_addr + 10'd1] <= pl_data[23:16];
      mem[pl_addr + 10'd2] <= pl_data[15:8];
      mem[pl_addr + 10'd3] <= pl_data[7:0];
    end else if (bus.mem_write) begin
      mem[rd_a]         <= bus.write_data[31:24];
      mem[rd_a + 10'd1] <= bus.write_data[23:16];
      mem[rd_a + 10'd2] <= bus.write_data[15:8];
      mem[rd_a + 10'd3] <= bus.write_data[7:0];
    end
  end

  int total;
  int bad;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  function automatic logic [31:0] exp_word(input int a);
    return {exp_mem[a], exp_mem[a+1], exp_mem[a+2], exp_mem[a+3]};
  endfunction

  task automatic set_exp_word(input int a, input logic [31:0] w);
    exp_mem[a]   = w[31:24];
    exp_mem[a+1] = w[23:16];
    exp_mem[a+2] = w[15:8];
    exp_mem[a+3] = w[7:0];
  endtask

  // Forward copy, one word at a time, in ascending order.
  task automatic model_copy(input int src, input int dst, input int len);
    for (int i = 0; i < len; i++) set_exp_word(dst + 4*i, exp_word(src + 4*i));
  endtask

  task automatic preload(input int a, input logic [31:0] w);
    @(negedge clk);
    pl_we   = 1'b1;
    pl_addr = 10'(a);
    pl_data = w;
    set_exp_word(a, w);
    @(negedge clk);
    pl_we   = 1'b0;
  endtask

  task automatic cmp_mem(input string nm);
    int nbad;
    int first;
    nbad  = 0;
    first = -1;
    for (int i = 0; i < 1024; i++) begin
      if (mem[i] !== exp_mem[i]) begin
        nbad++;
        if (first < 0) first = i;
      end
    end
    if (nbad != 0) $display("  first differing byte at 0x%0h", first);
    chk(nm, 64'(nbad), 64'd0);
  endtask

  // Issues one request and watches it until done/error. With inject set,
  // extra start pulses carrying other operands are driven mid-copy.
  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst,
                          input logic [15:0] len, input logic inject,
                          output int cyc, output logic saw_err,
                          output int acc, output int both, output int idle_junk,
                          output int busy_low, output logic busy_after);
    cyc = -1; saw_err = 1'b0; acc = 0; both = 0; idle_junk = 0; busy_low = 0;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.src_addr  = src;
    bus.dst_addr  = dst;
    bus.len_words = len;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (!bus.busy) busy_low++;
      if (bus.mem_read && bus.mem_write) both++;
      if (bus.mem_read || bus.mem_write) acc++;
      else if (bus.Addr != 32'd0 || bus.write_data != 32'd0) idle_junk++;
      if (bus.done || bus.error) begin
        cyc     = c;
        saw_err = bus.error;
        break;
      end
      if (inject && (c == 2 || c == 5)) begin
        bus.start     = 1'b1;
        bus.src_addr  = 32'h40;
        bus.dst_addr  = 32'h200;
        bus.len_words = 16'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    @(negedge clk);
    busy_after = bus.busy;
  endtask

  typedef struct {
    string       name;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [9];

  task automatic apply_vec(input vec_t v, input logic inject);
    int   cyc;
    logic serr;
    int   acc;
    int   both;
    int   junk;
    int   blow;
    logic bafter;
    run_copy(v.src, v.dst, v.len, inject, cyc, serr, acc, both, junk, blow, bafter);
    chk({v.name, " cycles"}, 64'(cyc), 64'(v.exp_cyc));
    chk({v.name, " error"}, 64'(serr), 64'(v.exp_err));
    chk({v.name, " accesses"}, 64'(acc), v.exp_err ? 64'd0 : 64'(2 * v.len));
    chk({v.name, " rd_wr_overlap"}, 64'(both), 64'd0);
    chk({v.name, " idle_bus_nonzero"}, 64'(junk), 64'd0);
    chk({v.name, " busy_gap"}, 64'(blow), 64'd0);
    chk({v.name, " busy_after"}, 64'(bafter), 64'd0);
    if (!v.exp_err) model_copy(int'(v.src), int'(v.dst), int'(v.len));
    cmp_mem({v.name, " memory"});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    pl_we = 1'b0;
    pl_addr = 10'd0;
    pl_data = 32'd0;
    bus.start = 1'b0;
    bus.src_addr = 32'd0;
    bus.dst_addr = 32'd0;
    bus.len_words = 16'd0;

    vecs[0] = '{"copy4",      32'h000,      32'h100, 16'd4,      1'b0, 9};
    vecs[1] = '{"len0",       32'h000,      32'h200, 16'd0,      1'b0, 1};
    vecs[2] = '{"src_misal",  32'h002,      32'h100, 16'd1,      1'b1, 1};
    vecs[3] = '{"src_range",  32'h3FC,      32'h000, 16'd2,      1'b1, 1};
    vecs[4] = '{"src_top",    32'h3FC,      32'h200, 16'd1,      1'b0, 3};
    vecs[5] = '{"dst_misal",  32'h010,      32'h101, 16'd1,      1'b1, 1};
    vecs[6] = '{"dst_top",    32'h010,      32'h3FC, 16'd1,      1'b0, 3};
    vecs[7] = '{"len0_end",   32'h400,      32'h000, 16'd0,      1'b0, 1};
    vecs[8] = '{"src_wrap",   32'hFFFFFFFC, 32'h000, 16'd2,      1'b1, 1};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset outputs",
        {bus.busy, bus.done, bus.error, bus.mem_read, bus.mem_write},
        64'd0);
    chk("reset addr_wdata", {bus.Addr, bus.write_data}, 64'd0);
    rst = 1'b0;

    for (int a = 0; a < 1024; a += 4) preload(a, $urandom);
    preload(32'h000, 32'h11111111);
    preload(32'h004, 32'h22222222);
    preload(32'h008, 32'h33333333);
    preload(32'h00C, 32'h44444444);

    for (int i = 0; i < 9; i++) apply_vec(vecs[i], 1'b0);
    chk("copy4 word3", 64'(mem_word(32'h10C)), 64'h44444444);

    // Overlapping regions copy forward.
    preload(32'h000, 32'hAAAA0001);
    preload(32'h004, 32'hBBBB0002);
    preload(32'h008, 32'hCCCC0003);
    apply_vec('{"overlap", 32'h000, 32'h004, 16'd2, 1'b0, 5}, 1'b0);
    chk("overlap 0x004", 64'(mem_word(32'h004)), 64'hAAAA0001);
    chk("overlap 0x008", 64'(mem_word(32'h008)), 64'hAAAA0001);

    // Start pulses during a copy are ignored.
    apply_vec('{"busy_start", 32'h000, 32'h380, 16'd3, 1'b0, 7}, 1'b1);

    // Reset during the write of word 2 of 4.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.src_addr  = 32'h000;
    bus.dst_addr  = 32'h300;
    bus.len_words = 16'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid write active", 64'(bus.mem_write), 64'd1);
    chk("rst_mid write addr", 64'(bus.Addr), 64'h304);
    rst = 1'b1;
    #1;
    chk("rst_mid outputs",
        {bus.busy, bus.done, bus.error, bus.mem_read, bus.mem_write},
        64'd0);
    chk("rst_mid addr_wdata", {bus.Addr, bus.write_data}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    set_exp_word(32'h300, exp_word(32'h000));
    cmp_mem("rst_mid memory");
    chk("rst_mid word1", 64'(mem_word(32'h300)), 64'(exp_word(32'h000)));
    apply_vec('{"after_rst", 32'h020, 32'h340, 16'd1, 1'b0, 3}, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
